// File: rtl/ssp_apb_if.sv
// APB register block for a PL022-style SSP: control/prescale/interrupt/DMA
// registers, TX and RX FIFOs, PrimeCell ID words and an internal loopback
// path that moves TX entries to RX in place of a serial engine.
module ssp_apb_if #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned RT_TIMEOUT = 32
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [9:0]  PADDR,
  input  logic [15:0] PWDATA,
  output logic [15:0] PRDATA,
  output logic        SSPRXINTR,
  output logic        SSPTXINTR,
  output logic        SSPRORINTR,
  output logic        SSPRTINTR,
  output logic        SSPINTR
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(RT_TIMEOUT + 1);

  logic [15:0]   cr0;
  logic [3:0]    cr1;
  logic [7:0]    cpsr;
  logic [3:0]    imsc;
  logic [1:0]    dmacr;
  logic          ris_ror;
  logic          ris_rt;

  logic [15:0]   tx_mem [FIFO_DEPTH];
  logic [15:0]   rx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic [TW-1:0] rt_cnt;

  logic          wr_en, rd_en;
  logic          tx_empty, tx_full, rx_empty, rx_full;
  logic          tx_push, tx_pop, rx_push, rx_pop;
  logic          xfer, overrun, rx_idle, rt_hit;
  logic          icr_ror, icr_rt;
  logic [15:0]   dss_mask;
  logic [4:0]    sr;
  logic [3:0]    ris, mis;

  assign wr_en    = PSEL & PENABLE & PWRITE;
  assign rd_en    = PSEL & PENABLE & ~PWRITE;

  assign tx_empty = (tx_cnt == '0);
  assign tx_full  = (tx_cnt == CW'(FIFO_DEPTH));
  assign rx_empty = (rx_cnt == '0);
  assign rx_full  = (rx_cnt == CW'(FIFO_DEPTH));

  // Loopback: a TX entry leaves every cycle while enabled; it lands in RX
  // unless RX is full, in which case it is discarded and flagged as overrun.
  assign xfer     = cr1[1] & cr1[0] & ~tx_empty;
  assign tx_pop   = xfer;
  assign rx_push  = xfer & ~rx_full;
  assign overrun  = xfer & rx_full;
  assign tx_push  = wr_en & (PADDR == 10'h002) & ~tx_full;
  assign rx_pop   = rd_en & (PADDR == 10'h002) & ~rx_empty;

  assign icr_ror  = wr_en & (PADDR == 10'h008) & PWDATA[0];
  assign icr_rt   = wr_en & (PADDR == 10'h008) & PWDATA[1];

  assign rx_idle  = ~rx_empty & ~rx_push & ~rx_pop;
  assign rt_hit   = rx_idle & (rt_cnt == TW'(RT_TIMEOUT - 1));

  assign sr  = {cr1[1] & ~tx_empty, rx_full, ~rx_empty, ~tx_full, tx_empty};
  assign ris = {(tx_cnt <= CW'(FIFO_DEPTH / 2)), (rx_cnt >= CW'(FIFO_DEPTH / 2)),
                ris_rt, ris_ror};
  assign mis = ris & imsc;

  assign SSPRORINTR = mis[0];
  assign SSPRTINTR  = mis[1];
  assign SSPRXINTR  = mis[2];
  assign SSPTXINTR  = mis[3];
  assign SSPINTR    = |mis;

  // Data-size mask: keep the low DSS+1 bits of a pushed word.
  always_comb begin
    dss_mask = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      dss_mask[i] = (i <= 32'(cr0[3:0]));
    end
  end

  // Control and configuration register writes.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      cr0   <= '0;
      cr1   <= '0;
      cpsr  <= '0;
      imsc  <= '0;
      dmacr <= '0;
    end else if (wr_en) begin
      case (PADDR)
        10'h000: cr0   <= PWDATA;
        10'h001: cr1   <= PWDATA[3:0];
        10'h004: cpsr  <= {PWDATA[7:1], 1'b0};
        10'h005: imsc  <= PWDATA[3:0];
        10'h009: dmacr <= PWDATA[1:0];
        default: ;
      endcase
    end
  end

  // FIFO storage; contents are don't-care while the matching count is zero.
  always_ff @(posedge PCLK) begin
    if (tx_push) tx_mem[tx_wp] <= PWDATA & dss_mask;
    if (rx_push) rx_mem[rx_wp] <= tx_mem[tx_rp];
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + 1'b1;
        2'b01:   tx_cnt <= tx_cnt - 1'b1;
        default: ;
      endcase
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + 1'b1;
        2'b01:   rx_cnt <= rx_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // Raw interrupt flags and RX idle timer. RT fires on the step into the
  // timeout value, so clearing it via ICR while still idle does not re-fire.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      rt_cnt  <= '0;
      ris_rt  <= 1'b0;
      ris_ror <= 1'b0;
    end else begin
      if (!rx_idle)                          rt_cnt <= '0;
      else if (rt_cnt != TW'(RT_TIMEOUT))    rt_cnt <= rt_cnt + 1'b1;

      if (rt_hit)                            ris_rt <= 1'b1;
      else if (rx_empty || icr_rt)           ris_rt <= 1'b0;

      if (overrun)                           ris_ror <= 1'b1;
      else if (icr_ror)                      ris_ror <= 1'b0;
    end
  end

  // Combinational read mux; driven only during a read selection.
  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE) begin
      case (PADDR)
        10'h000: PRDATA = cr0;
        10'h001: PRDATA = {12'h000, cr1};
        10'h002: PRDATA = rx_empty ? 16'h0000 : rx_mem[rx_rp];
        10'h003: PRDATA = {11'h000, sr};
        10'h004: PRDATA = {8'h00, cpsr};
        10'h005: PRDATA = {12'h000, imsc};
        10'h006: PRDATA = {12'h000, ris};
        10'h007: PRDATA = {12'h000, mis};
        10'h009: PRDATA = {14'h0000, dmacr};
        10'h3F8: PRDATA = 16'h0022;
        10'h3F9: PRDATA = 16'h0010;
        10'h3FA: PRDATA = 16'h0034;
        10'h3FB: PRDATA = 16'h0000;
        10'h3FC: PRDATA = 16'h000D;
        10'h3FD: PRDATA = 16'h00F0;
        10'h3FE: PRDATA = 16'h0005;
        10'h3FF: PRDATA = 16'h00B1;
        default: PRDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ssp_apb_if.sv
// Scoreboard bench for ssp_apb_if: reads push expected data (and optionally
// expected interrupt pins) into a queue; a monitor compares on each read access.
module tb_ssp_apb_if;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [9:0]  PADDR = '0;
  logic [15:0] PWDATA = '0;
  logic [15:0] PRDATA;
  logic        SSPRXINTR, SSPTXINTR, SSPRORINTR, SSPRTINTR, SSPINTR;

  ssp_apb_if #(.FIFO_DEPTH(8), .RT_TIMEOUT(32)) dut (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PADDR      (PADDR),
    .PWDATA     (PWDATA),
    .PRDATA     (PRDATA),
    .SSPRXINTR  (SSPRXINTR),
    .SSPTXINTR  (SSPTXINTR),
    .SSPRORINTR (SSPRORINTR),
    .SSPRTINTR  (SSPRTINTR),
    .SSPINTR    (SSPINTR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [9:0]  addr;
    logic [15:0] data;
    logic [4:0]  irq;   // {INTR, TX, RX, RT, ROR}
    bit          chk_irq;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  logic [4:0] irq_vec;

  assign irq_vec = {SSPINTR, SSPTXINTR, SSPRXINTR, SSPRTINTR, SSPRORINTR};

  // Monitor: compare every APB read access against the scoreboard head.
  always @(negedge PCLK) begin
    if (PSEL && PENABLE && !PWRITE) begin
      if (sbq.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_read addr=%h got=%h want=none", PADDR, PRDATA);
      end else begin
        mon_e = sbq.pop_front();
        total_cnt++;
        if (PRDATA !== mon_e.data)
          $display("FAIL read addr=%h got=%h want=%h", mon_e.addr, PRDATA, mon_e.data);
        else
          pass_cnt++;
        if (mon_e.chk_irq) begin
          total_cnt++;
          if (irq_vec !== mon_e.irq)
            $display("FAIL irq_pins addr=%h got=%b want=%b", mon_e.addr, irq_vec, mon_e.irq);
          else
            pass_cnt++;
        end
      end
    end
  end

  task automatic apb_wr(input logic [9:0] a, input logic [15:0] d);
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_rd(input logic [9:0] a, input logic [15:0] d,
                        input logic [4:0] irq, input bit ci);
    exp_t e;
    e.addr = a; e.data = d; e.irq = irq; e.chk_irq = ci;
    sbq.push_back(e);
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = a;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic do_reset();
    PRESET = 1'b1;
    repeat (3) @(posedge PCLK);
    #1;
    PRESET = 1'b0;
  endtask

  logic [15:0] rst_exp [11];
  logic [7:0]  ids [8];

  initial begin
    rst_exp = '{16'h0000, 16'h0000, 16'h0000, 16'h0003, 16'h0000, 16'h0000,
                16'h0008, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    ids = '{8'h22, 8'h10, 8'h34, 8'h00, 8'h0D, 8'hF0, 8'h05, 8'hB1};

    // Reset values of the whole map plus IDs; interrupt pins low.
    do_reset();
    apb_rd(10'h006, 16'h0008, 5'b00000, 1'b1);
    for (int i = 0; i < 11; i++) apb_rd(10'(i), rst_exp[i], 5'b00000, 1'b0);
    for (int i = 0; i < 8; i++) apb_rd(10'h3F8 + 10'(i), {8'h00, ids[i]}, 5'b00000, 1'b0);

    // Register write/readback, including CPSR bit0 and CR1 width.
    apb_wr(10'h000, 16'hA5C7); apb_rd(10'h000, 16'hA5C7, 5'b0, 1'b0);
    apb_wr(10'h004, 16'h00FF); apb_rd(10'h004, 16'h00FE, 5'b0, 1'b0);
    apb_wr(10'h005, 16'h000F); apb_rd(10'h005, 16'h000F, 5'b0, 1'b0);
    apb_wr(10'h009, 16'h0003); apb_rd(10'h009, 16'h0003, 5'b0, 1'b0);
    apb_wr(10'h001, 16'h001F); apb_rd(10'h001, 16'h000F, 5'b0, 1'b0);
    // TX level (empty TX) unmasked -> MIS=8, TX and combined pins high.
    apb_rd(10'h007, 16'h0008, 5'b11000, 1'b1);

    // Fill TX with SSE off, ninth write dropped, then loop back into RX.
    do_reset();
    apb_wr(10'h000, 16'h000F);
    for (int i = 0; i < 8; i++) apb_wr(10'h002, 16'h1000 + 16'(i));
    apb_rd(10'h003, 16'h0000, 5'b0, 1'b0);
    apb_wr(10'h002, 16'hDEAD);
    apb_rd(10'h003, 16'h0000, 5'b0, 1'b0);
    apb_wr(10'h001, 16'h0003);
    repeat (12) @(posedge PCLK);
    #1;
    apb_rd(10'h003, 16'h000F, 5'b0, 1'b0);
    apb_rd(10'h006, 16'h000C, 5'b0, 1'b0);
    for (int i = 0; i < 8; i++) apb_rd(10'h002, 16'h1000 + 16'(i), 5'b0, 1'b0);
    apb_rd(10'h002, 16'h0000, 5'b0, 1'b0);
    apb_rd(10'h003, 16'h0003, 5'b0, 1'b0);

    // Data-size masking: DSS=7 keeps 8 bits.
    do_reset();
    apb_wr(10'h000, 16'h0007);
    apb_wr(10'h001, 16'h0003);
    apb_wr(10'h002, 16'h1234);
    apb_rd(10'h002, 16'h0034, 5'b0, 1'b0);
    apb_rd(10'h003, 16'h0003, 5'b0, 1'b0);

    // Overrun: ninth entry with RX full sets ROR; ICR clears it.
    do_reset();
    apb_wr(10'h000, 16'h000F);
    apb_wr(10'h001, 16'h0003);
    for (int i = 0; i < 9; i++) apb_wr(10'h002, 16'h0050 + 16'(i));
    apb_wr(10'h005, 16'h0001);
    apb_rd(10'h006, 16'h000D, 5'b0, 1'b0);
    apb_rd(10'h007, 16'h0001, 5'b10001, 1'b1);
    apb_wr(10'h008, 16'h0001);
    apb_rd(10'h006, 16'h000C, 5'b0, 1'b0);
    apb_rd(10'h007, 16'h0000, 5'b00000, 1'b1);

    // RX timeout after 32 idle cycles; a DR read clears it.
    do_reset();
    apb_wr(10'h000, 16'h000F);
    apb_wr(10'h001, 16'h0003);
    apb_wr(10'h005, 16'h0002);
    apb_wr(10'h002, 16'h00AB);
    repeat (40) @(posedge PCLK);
    #1;
    apb_rd(10'h006, 16'h000A, 5'b0, 1'b0);
    apb_rd(10'h007, 16'h0002, 5'b10010, 1'b1);
    apb_rd(10'h002, 16'h00AB, 5'b0, 1'b0);
    apb_rd(10'h007, 16'h0000, 5'b00000, 1'b1);
    apb_rd(10'h006, 16'h0008, 5'b0, 1'b0);

    // Mid-transfer reset returns everything to reset values.
    apb_wr(10'h001, 16'h0000);
    for (int i = 0; i < 4; i++) apb_wr(10'h002, 16'h0777);
    apb_wr(10'h001, 16'h0003);
    do_reset();
    apb_rd(10'h003, 16'h0003, 5'b0, 1'b0);
    apb_rd(10'h001, 16'h0000, 5'b00000, 1'b1);
    apb_rd(10'h002, 16'h0000, 5'b0, 1'b0);

    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge PCLK);
    if (sbq.size() != 0) begin
      total_cnt++;
      $display("FAIL drain pending=%0d want=0", sbq.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
